// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared constants and FSM state type for the mux scan sequencer.
//   NUM_CH / CH_W / DATA_W describe the 8-to-1, 4-bit channel multiplexer
//   being scanned.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch
//   Combinational channel picker.
//   Ports:
//     mask    in  NUM_CH : enabled-channel mask
//     cur_ch  in  CH_W   : current channel
//     next_ch out CH_W   : lowest set channel strictly above cur_ch
//     wrap    out 1      : no set channel above cur_ch
//     lowest  out CH_W   : lowest set channel in mask (0 when mask is 0)
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              wrap,
    output logic [CH_W-1:0]   lowest
);

    always_comb begin
        next_ch = '0;
        wrap    = 1'b1;
        lowest  = '0;
        // Walking downward means the last hit is the lowest qualifying bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = CH_W'(i);
                if (CH_W'(i) > cur_ch) begin
                    next_ch = CH_W'(i);
                    wrap    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Scans the enabled channels of an 8-to-1 mux: selects a channel, waits
//   SETTLE_CYCLES, captures mux_data and offers (chan, data) on a
//   valid/ready port. Single-pass or continuous scanning.
//   Ports:
//     clk, rst_n (sync, active-low)
//     start, stop, continuous, chan_mask[7:0]  : control
//     mux_data[3:0]                            : mux output
//     sel0/sel1/sel2, mux_enable               : mux control
//     out_valid, out_ready, out_chan, out_data : sample port
//     busy, scan_done                          : status
//   All outputs come straight from flops.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic [DATA_W-1:0] mux_data,
    output logic              sel0,
    output logic              sel1,
    output logic              sel2,
    output logic              mux_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_chan,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              scan_done
);

    scan_state_t       state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              cont_q, cont_d;
    logic              stop_pending_q, stop_pending_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_chan_q, out_chan_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              scan_done_q, scan_done_d;

    // Walk of the latched mask from the current channel.
    logic [CH_W-1:0]   walk_next, walk_lowest;
    logic              walk_wrap;

    mux_scan_next_ch u_walk (
        .mask    (mask_q),
        .cur_ch  (sel_q),
        .next_ch (walk_next),
        .wrap    (walk_wrap),
        .lowest  (walk_lowest)
    );

    // First channel of a freshly latched mask (start or continuous wrap).
    logic [CH_W-1:0]   new_lowest, new_next_unused;
    logic              new_wrap_unused;

    mux_scan_next_ch u_first (
        .mask    (chan_mask),
        .cur_ch  ('0),
        .next_ch (new_next_unused),
        .wrap    (new_wrap_unused),
        .lowest  (new_lowest)
    );

    logic unused_walk;
    assign unused_walk = &{1'b0, walk_lowest, new_next_unused, new_wrap_unused};

    wire mask_nz   = |chan_mask;
    wire handshake = out_valid_q & out_ready;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        cont_d         = cont_q;
        stop_pending_d = stop_pending_q;
        out_valid_d    = out_valid_q;
        out_chan_d     = out_chan_q;
        out_data_d     = out_data_q;
        scan_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop && mask_nz) begin
                    mask_d  = chan_mask;
                    cont_d  = continuous;
                    sel_d   = new_lowest;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    out_data_d  = mux_data;
                    out_chan_d  = sel_q;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUTPUT: begin
                if (stop) stop_pending_d = 1'b1;
                if (handshake) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    if (stop || stop_pending_q) begin
                        // Abort is taken only once the held word is delivered.
                        stop_pending_d = 1'b0;
                        state_d        = IDLE;
                    end else if (!walk_wrap) begin
                        sel_d   = walk_next;
                        state_d = SETTLE;
                    end else begin
                        scan_done_d = 1'b1;
                        state_d     = IDLE;
                        if (cont_q) begin
                            mask_d = chan_mask;
                            cont_d = continuous;
                            if (mask_nz) begin
                                sel_d   = new_lowest;
                                state_d = SETTLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            cnt_q          <= '0;
            mask_q         <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_chan_q     <= '0;
            out_data_q     <= '0;
            scan_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            cont_q         <= cont_d;
            stop_pending_q <= stop_pending_d;
            out_valid_q    <= out_valid_d;
            out_chan_q     <= out_chan_d;
            out_data_q     <= out_data_d;
            scan_done_q    <= scan_done_d;
        end
    end

    assign {sel2, sel1, sel0} = sel_q;
    assign busy       = (state_q != IDLE);
    assign mux_enable = busy;
    assign out_valid  = out_valid_q;
    assign out_chan   = out_chan_q;
    assign out_data   = out_data_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//   Directed bench for mux_scan_sequencer (SETTLE_CYCLES=2) with a table
//   model of the 8-to-1 mux driving mux_data from the selects.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, continuous, out_ready;
    logic [7:0] chan_mask;
    logic [3:0] mux_data;
    logic       sel0, sel1, sel2, mux_enable, out_valid, busy, scan_done;
    logic [2:0] out_chan;
    logic [3:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [3:0] mux_tbl [8];
    logic [2:0] sel_vec;

    assign sel_vec  = {sel2, sel1, sel0};
    assign mux_data = mux_tbl[sel_vec];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_mask  (chan_mask),
        .mux_data   (mux_data),
        .sel0       (sel0),
        .sel1       (sel1),
        .sel2       (sel2),
        .mux_enable (mux_enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_data   (out_data),
        .busy       (busy),
        .scan_done  (scan_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid, then checks the offered word.
    task automatic expect_word(input string tag, input logic [2:0] ch, input logic [3:0] dat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_chan"}, out_chan, ch);
        chk({tag, "_data"}, out_data, dat);
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic c);
        chan_mask  = m;
        continuous = c;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        mux_tbl = '{4'd15, 4'd1, 4'd2, 4'd15, 4'd4, 4'd5, 4'd15, 4'd7};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        out_ready = 1'b1; chan_mask = 8'h00;
        step(); step();

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", mux_enable, 0);
        chk("rst_sel", sel_vec, 0);
        chk("rst_done", scan_done, 0);
        rst_n = 1'b1;
        step();

        // Full single pass, exact cadence
        pulse_start(8'hFF, 1'b0);
        chk("fp_busy", busy, 1);
        chk("fp_en", mux_enable, 1);
        chk("fp_sel0", sel_vec, 0);
        chk("fp_v1", out_valid, 0);
        step();
        chk("fp_v2", out_valid, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("fp_valid", out_valid, 1);
            chk("fp_chan", out_chan, k);
            chk("fp_data", out_data, mux_tbl[k]);
            step();
            if (k < 7) begin
                chk("fp_gap_v", out_valid, 0);
                chk("fp_nsel", sel_vec, k + 1);
                chk("fp_nodone", scan_done, 0);
                step();
                chk("fp_gap_v2", out_valid, 0);
                step();
            end else begin
                chk("fp_done", scan_done, 1);
                chk("fp_idle", busy, 0);
                chk("fp_en_off", mux_enable, 0);
                step();
                chk("fp_done_pulse", scan_done, 0);
            end
        end

        // Sparse mask
        pulse_start(8'b1010_0100, 1'b0);
        expect_word("sp_w0", 3'd2, 4'd2); step();
        expect_word("sp_w1", 3'd5, 4'd5); step();
        expect_word("sp_w2", 3'd7, 4'd7); step();
        chk("sp_done", scan_done, 1);
        chk("sp_idle", busy, 0);
        step();

        // Backpressure on the channel 1 word
        pulse_start(8'h07, 1'b0);
        expect_word("bp_w0", 3'd0, 4'd15); step();
        out_ready = 1'b0;
        expect_word("bp_w1", 3'd1, 4'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_v", out_valid, 1);
            chk("bp_hold_c", out_chan, 1);
            chk("bp_hold_d", out_data, 1);
            chk("bp_hold_sel", sel_vec, 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_nsel", sel_vec, 2);
        chk("bp_v_low", out_valid, 0);
        expect_word("bp_w2", 3'd2, 4'd2); step();
        chk("bp_done", scan_done, 1);
        step();

        // Continuous mode, mask changed mid-pass
        pulse_start(8'h81, 1'b1);
        expect_word("ct_w0", 3'd0, 4'd15); step();
        chk("ct_nodone0", scan_done, 0);
        expect_word("ct_w1", 3'd7, 4'd7); step();
        chk("ct_done1", scan_done, 1);
        chk("ct_busy1", busy, 1);
        expect_word("ct_w2", 3'd0, 4'd15); step();
        chan_mask = 8'h02;
        expect_word("ct_w3", 3'd7, 4'd7); step();
        chk("ct_done2", scan_done, 1);
        expect_word("ct_w4", 3'd1, 4'd1); step();
        chk("ct_done3", scan_done, 1);
        expect_word("ct_w5", 3'd1, 4'd1); step();
        chk("ct_done4", scan_done, 1);

        // Stop during SETTLE (block is settling on channel 1 now)
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("ss_idle", busy, 0);
        chk("ss_v", out_valid, 0);
        step(); step(); step();
        chk("ss_noword", out_valid, 0);
        chk("ss_nodone", scan_done, 0);

        // Stop during OUTPUT with backpressure
        out_ready = 1'b0;
        pulse_start(8'hFF, 1'b0);
        expect_word("so_w0", 3'd0, 4'd15);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("so_held", out_valid, 1);
        chk("so_busy", busy, 1);
        out_ready = 1'b1;
        step();
        chk("so_idle", busy, 0);
        chk("so_nodone", scan_done, 0);
        chk("so_v", out_valid, 0);
        step();

        // Reset mid-OUTPUT
        out_ready = 1'b0;
        pulse_start(8'hFF, 1'b0);
        expect_word("rs_w", 3'd0, 4'd15);
        rst_n = 1'b0;
        step();
        chk("rs_v", out_valid, 0);
        chk("rs_chan", out_chan, 0);
        chk("rs_data", out_data, 0);
        chk("rs_sel", sel_vec, 0);
        chk("rs_busy", busy, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Start with mask 0 is ignored
        pulse_start(8'h00, 1'b0);
        chk("m0_busy", busy, 0);
        step();
        chk("m0_busy2", busy, 0);

        // Start together with stop is ignored
        stop = 1'b1;
        pulse_start(8'hFF, 1'b0);
        stop = 1'b0;
        chk("ssm_busy", busy, 0);

        // Start while busy is ignored (mask not re-latched)
        pulse_start(8'h01, 1'b0);
        pulse_start(8'hFF, 1'b1);
        expect_word("sb_w0", 3'd0, 4'd15); step();
        chk("sb_done", scan_done, 1);
        chk("sb_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream controller for the 8-to-1, 4-bit channel multiplexer. It walks the selects through the enabled channels, waits a programmable settle time on each one, and captures the mux output. Each sample is presented as a (channel, data) word on a valid/ready output port. It replaces hand-driven `sel2..sel0`/`enable` stimulus with a scan that runs under a single clock.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each channel stays selected before capture. Legal range 1..15.
- `CNT_W`, default 4: settle counter width. Must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle request to begin a scan. Honoured only in IDLE.
- `stop` in 1: abort request.
- `continuous` in 1: 1 = rescan forever, 0 = single pass. Sampled at start and at each wrap.
- `chan_mask` in 8: bit i enables channel i. Latched at start and at each wrap.
- `mux_data` in 4: multiplexer output.
- `sel0`, `sel1`, `sel2` out 1 each: mux selects; `{sel2,sel1,sel0}` is the current channel.
- `mux_enable` out 1: mux enable, high while busy.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_chan` out 3: channel of the captured word.
- `out_data` out 4: captured data.
- `busy` out 1: high in any state other than IDLE.
- `scan_done` out 1: one-cycle pulse when a pass completes.

## Operation
- States: IDLE, SETTLE, OUTPUT.
- IDLE:
  - `start`=1 and `chan_mask`≠0: latch mask and `continuous`, select the lowest set channel, clear settle counter, go to SETTLE.
  - `start` with mask 0 is ignored.
  - `start` and `stop` in the same cycle: `stop` wins, block stays in IDLE.
- SETTLE:
  - Selects are held and `mux_enable`=1; counter increments each cycle.
  - In the cycle the counter reaches SETTLE_CYCLES-1, `mux_data` and the channel are registered into `out_data`/`out_chan`, `out_valid` is set, and the state goes to OUTPUT.
  - `stop` in SETTLE: go to IDLE next cycle, no word, no `scan_done`.
- OUTPUT:
  - `out_valid`, `out_chan`, `out_data` and the selects hold stable until `out_valid & out_ready`.
  - `stop` here sets `stop_pending`. After the handshake the block goes to IDLE with no `scan_done`.
  - On handshake without `stop_pending`, the next set latched-mask bit strictly above the current channel is selected and the state goes to SETTLE.
  - If there is no higher set bit (wrap): pulse `scan_done`. Then:
    - `continuous`=0: go to IDLE.
    - `continuous`=1: re-latch `chan_mask`/`continuous`. New mask ≠0 → lowest set channel, SETTLE. New mask =0 → IDLE.
- `start` while busy is ignored. Changes to `chan_mask` between wraps have no effect.
- Reset (`rst_n`=0 at an edge), from any state: all outputs 0, selects 0, `stop_pending` cleared, state IDLE.

## Timing
- `start` high at edge N → selects valid and `busy`/`mux_enable` high from cycle N+1.
- Capture happens in cycle N+SETTLE_CYCLES. `out_valid` is high from cycle N+1+SETTLE_CYCLES.
- Handshake at edge K → next channel's selects from cycle K+1, `out_valid` low in K+1 .. K+SETTLE_CYCLES, high again at K+1+SETTLE_CYCLES.
- With `out_ready` held at 1, throughput is one word per SETTLE_CYCLES+1 cycles.
- `scan_done` is high in cycle K+1 after the wrap handshake.
- In single-pass mode, `busy` and `mux_enable` fall in that same cycle.
- Outputs are registered only; there is no combinational path from any input to any output.

## Structure
- Package `mux_scan_pkg` holds:
  - constants `NUM_CH`=8, `CH_W`=3, `DATA_W`=4;
  - the state enum `scan_state_t` {IDLE, SETTLE, OUTPUT}.
- Sub-module `mux_scan_next_ch` (combinational), given the mask and current channel, returns:
  - the next set channel strictly above the current one;
  - a `wrap` flag;
  - the lowest set channel.

## Test plan
- Full single pass:
  - Setup: SETTLE_CYCLES=2; mux model with ch0..7 = 15,1,2,15,4,5,15,7; mask 8'hFF; `continuous`=0; `out_ready`=1.
  - Required: 8 words (chan,data) = (0,15),(1,1)…(7,7); first `out_valid` 3 cycles after `start`, then one word every 3 cycles; one `scan_done` pulse; `busy` then 0.
- Sparse mask 8'b1010_0100 → words for channels 2, 5, 7 only (data 2, 5, 7), then `scan_done`.
- Backpressure: `out_ready`=0 for 5 cycles on the channel 1 word → `out_valid`=1 and chan=1, data=1 held; selects stay 3'd1; next channel selected only after `out_ready` returns high.
- Continuous mode:
  - Setup: `continuous`=1, mask 8'h81.
  - Required: channel sequence 0,7,0,7 with `scan_done` at each wrap.
  - Then: mask changed to 8'h02 mid-pass → takes effect only after the next wrap, sequence continues 1,1,…
- Stop:
  - `stop` during SETTLE → IDLE next cycle, no word emitted.
  - `stop` during OUTPUT with `out_ready`=0 → the word is still delivered when `out_ready` rises; then IDLE, no `scan_done`.
- Reset and ignored starts:
  - `rst_n`=0 mid-OUTPUT → next cycle all outputs 0 and state IDLE.
  - `start` with mask 0 → `busy` stays 0.
  - `start` while busy → ignored.
